// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// LOADER_CHECKSUM_EN adds the CHECK state to the state encoding.
package imem_loader_pkg;

    localparam int DEFAULT_AW = 10;
    localparam int WORD_BYTES = 4;

    typedef logic [$clog2(WORD_BYTES)-1:0] byte_idx_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian 32-bit words from a byte stream.
// The first byte lands in bits [7:0]. 'full' is high on the cycle the fourth byte
// is shifted in, and 'word' then presents the complete assembled word.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        full
);

    logic [23:0] held;
    byte_idx_t   count;

    assign full = shift_en && (count == byte_idx_t'(WORD_BYTES - 1));
    assign word = {byte_in, held};

    // Shift accepted bytes down from the top and count them; clear drops any partial word
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            held  <= '0;
            count <= '0;
        end else if (shift_en) begin
            held  <= {byte_in, held[23:8]};
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory, one 32-bit word per write.
// Optional feature macro: LOADER_CHECKSUM_EN. When it is defined, four trailing
// checksum bytes are received and compared against the running sum of the written words.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int AW = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   len_words,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [31:0]   wdata,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t      state;
    logic [AW:0] len_latched;
    logic [AW:0] words_written;
    logic [AW:0] words_next;
    logic        accept;
    logic        packer_clear;
    logic        word_full;
    logic [31:0] packed_word;

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum;
    logic        err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign accept       = in_valid && in_ready;
    assign packer_clear = (state == S_IDLE);
    assign words_next   = words_written + 1'b1;
    assign busy         = (state != S_IDLE);

    byte_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear    (packer_clear),
        .shift_en (accept),
        .byte_in  (in_data),
        .word     (packed_word),
        .full     (word_full)
    );

    // Load sequencer: latch the request, gather words, pulse the write, then finish
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            in_ready      <= 1'b0;
            we            <= 1'b0;
            done          <= 1'b0;
            waddr         <= '0;
            wdata         <= '0;
            len_latched   <= '0;
            words_written <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum           <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_latched   <= len_words;
                        words_written <= '0;
                        waddr         <= '0;
`ifdef LOADER_CHECKSUM_EN
                        sum           <= '0;
                        err_q         <= 1'b0;
`endif
                        if (len_words == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= S_RECV;
                            in_ready <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    if (word_full) begin
                        wdata    <= packed_word;
                        we       <= 1'b1;
                        in_ready <= 1'b0;
                        state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    waddr         <= waddr + 1'b1;
                    words_written <= words_next;
`ifdef LOADER_CHECKSUM_EN
                    sum           <= sum + wdata;
`endif
                    if (words_next == len_latched) begin
`ifdef LOADER_CHECKSUM_EN
                        state    <= S_CHECK;
                        in_ready <= 1'b1;
`else
                        state    <= S_DONE;
                        done     <= 1'b1;
`endif
                    end else begin
                        state    <= S_RECV;
                        in_ready <= 1'b1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (word_full) begin
                        err_q    <= (packed_word != sum);
                        in_ready <= 1'b0;
                        state    <= S_DONE;
                        done     <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (small address space so the full-depth load is quick).
module tb_imem_loader;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   len_words;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic          busy;
    logic          done;
    logic          err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int doneCount = 0;
    int doneCyc = 0;
    int startCyc = 0;
    int readyInWrite = 0;

    logic [AW-1:0] wrAddr[$];
    logic [31:0]   wrData[$];
    int            wrCyc[$];
    logic [7:0]    byteQ[$];
    logic [31:0]   expQ[$];

    // One load: stream[0] is the first byte sent, expw[0] the first word expected
    typedef struct {
        int               len;
        bit               gap;
        bit               midStart;
        logic [0:15][7:0] stream;
        logic [0:3][31:0] expw;
    } vec_t;

    vec_t vecs[5];

    imem_loader #(.AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len_words (len_words),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Cycle counter, advanced on the active edge
    always @(posedge clk) cyc <= cyc + 1;

    // Observe writes and done pulses mid-cycle
    always @(negedge clk) begin
        if (we) begin
            wrAddr.push_back(waddr);
            wrData.push_back(wdata);
            wrCyc.push_back(cyc);
            if (in_ready) readyInWrite <= readyInWrite + 1;
        end
        if (done) begin
            doneCount <= doneCount + 1;
            doneCyc   <= cyc;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Present one byte and hold it until the loader takes it
    task automatic sendByte(input logic [7:0] b, input bit gap);
        int guard;
        guard = 0;
        if (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) checkOutput("byte accept timeout", 32'd1, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Run a complete load from byteQ and compare the resulting writes with expQ
    task automatic runLoad(input int len, input bit gap, input bit midStart, input int csumAdj, input string tag);
        int         doneBefore;
        int         guard;
        logic       expErr;
        logic [31:0] ck;
        wrAddr.delete();
        wrData.delete();
        wrCyc.delete();
        doneBefore = doneCount;
        @(negedge clk);
        start     = 1'b1;
        len_words = (AW+1)'(len);
        startCyc  = cyc;
        @(negedge clk);
        start     = 1'b0;
        len_words = '0;
        for (int i = 0; i < byteQ.size(); i++) begin
            if (midStart && i == 2) begin
                start     = 1'b1;
                len_words = 5'd7;
            end
            sendByte(byteQ[i], gap);
            start     = 1'b0;
            len_words = '0;
        end
`ifdef LOADER_CHECKSUM_EN
        ck = 32'd0;
        foreach (expQ[i]) ck = ck + expQ[i];
        ck = ck + 32'(csumAdj);
        for (int k = 0; k < 4; k++) sendByte(ck[8*k +: 8], gap);
        expErr = (csumAdj != 0);
`else
        ck = 32'd0;
        expErr = 1'b0;
`endif
        guard = 0;
        while (doneCount == doneBefore && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        checkOutput({tag, " done pulses"}, 32'(doneCount - doneBefore), 32'd1);
        checkOutput({tag, " write count"}, 32'(wrAddr.size()), 32'(len));
        for (int i = 0; i < wrAddr.size() && i < expQ.size(); i++) begin
            checkOutput($sformatf("%s addr %0d", tag, i), 32'(wrAddr[i]), 32'(i % DEPTH));
            checkOutput($sformatf("%s data %0d", tag, i), wrData[i], expQ[i]);
            if (!gap && i > 0)
                checkOutput($sformatf("%s spacing %0d", tag, i), 32'(wrCyc[i] - wrCyc[i-1]), 32'd5);
        end
        if (len == 0)
            checkOutput({tag, " done latency"}, 32'(doneCyc - startCyc), 32'd1);
`ifndef LOADER_CHECKSUM_EN
        if (len > 0 && wrCyc.size() > 0)
            checkOutput({tag, " done after last write"}, 32'(doneCyc - wrCyc[wrCyc.size()-1]), 32'd1);
`endif
        if (!gap && len > 0 && wrCyc.size() > 0)
            checkOutput({tag, " first write latency"}, 32'(wrCyc[0] - startCyc), 32'd5);
        checkOutput({tag, " final waddr"}, 32'(waddr), 32'(len % DEPTH));
        checkOutput({tag, " err"}, 32'(err), 32'(expErr));
        checkOutput({tag, " busy after done"}, 32'(busy), 32'd0);
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        byteQ.delete();
        expQ.delete();
        for (int i = 0; i < 4 * v.len; i++) byteQ.push_back(v.stream[i]);
        for (int i = 0; i < v.len; i++) expQ.push_back(v.expw[i]);
        runLoad(v.len, v.gap, v.midStart, 0, tag);
    endtask

    initial begin
        vecs[0] = '{len: 2, gap: 1'b0, midStart: 1'b0,
                    stream: 128'h13000000_37010000_00000000_00000000,
                    expw:   128'h00000013_00000137_00000000_00000000};
        vecs[1] = '{len: 1, gap: 1'b1, midStart: 1'b0,
                    stream: 128'hEFBEADDE_00000000_00000000_00000000,
                    expw:   128'hDEADBEEF_00000000_00000000_00000000};
        vecs[2] = '{len: 3, gap: 1'b0, midStart: 1'b1,
                    stream: 128'h01020304_AABBCCDD_10203040_00000000,
                    expw:   128'h04030201_DDCCBBAA_40302010_00000000};
        vecs[3] = '{len: 0, gap: 1'b0, midStart: 1'b0,
                    stream: 128'h0,
                    expw:   128'h0};
        vecs[4] = '{len: 4, gap: 1'b1, midStart: 1'b0,
                    stream: 128'hFF00FF00_807F01FE_00000080_55555555,
                    expw:   128'h00FF00FF_FE017F80_80000000_55555555};

        rst       = 1'b1;
        start     = 1'b0;
        len_words = '0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset we", 32'(we), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset err", 32'(err), 32'd0);
        checkOutput("reset waddr", 32'(waddr), 32'd0);
        checkOutput("reset wdata", wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) applyStimulus(vecs[v], $sformatf("vec%0d", v));

        // Reset in the middle of a word: nothing written, then a clean load from address 0
        wrAddr.delete();
        wrData.delete();
        wrCyc.delete();
        start     = 1'b1;
        len_words = 5'd2;
        @(negedge clk);
        start     = 1'b0;
        len_words = '0;
        sendByte(8'hAA, 1'b0);
        sendByte(8'hBB, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset in_ready", 32'(in_ready), 32'd0);
        checkOutput("midreset busy", 32'(busy), 32'd0);
        checkOutput("midreset waddr", 32'(waddr), 32'd0);
        checkOutput("midreset wdata", wdata, 32'd0);
        checkOutput("midreset we", 32'(we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset no writes", 32'(wrAddr.size()), 32'd0);
        byteQ = '{8'h11, 8'h22, 8'h33, 8'h44};
        expQ  = '{32'h44332211};
        runLoad(1, 1'b0, 1'b0, 0, "after reset");

        // Checksum words 1 and 2: correct trailer, then a trailer off by one
        byteQ = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        expQ  = '{32'h00000001, 32'h00000002};
        runLoad(2, 1'b0, 1'b0, 0, "csum good");
        runLoad(2, 1'b0, 1'b0, 1, "csum bad");

        // Full-depth load: every address written once and the address wraps to 0
        byteQ.delete();
        expQ.delete();
        for (int w = 0; w < DEPTH; w++) begin
            for (int k = 0; k < 4; k++) byteQ.push_back(8'(4 * w + k));
            expQ.push_back({8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1), 8'(4 * w)});
        end
        runLoad(DEPTH, 1'b0, 1'b0, 0, "full depth");

        checkOutput("in_ready during write", 32'(readyInWrite), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
